// File: rtl/alien_fleet_ctrl.sv
// alien_fleet_ctrl: alien formation state (live grid, origin, march), bullet hits, cleared/landed flags.
// Define ALIEN_SPEEDUP_EN to shorten the march period as aliens are killed.
module alien_fleet_ctrl #(
    parameter int ALIEN_W     = 30,
    parameter int ALIEN_H     = 20,
    parameter int SPACE_X     = 10,
    parameter int SPACE_Y     = 10,
    parameter int START_COL   = 20,
    parameter int START_ROW   = 40,
    parameter int STEP_X      = 4,
    parameter int STEP_Y      = 10,
    parameter int STEP_FRAMES = 30,
    parameter int SCREEN_W    = 640,
    parameter int LAND_ROW    = 440
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        FrameTick,
    input  logic        Restart,
    input  logic        BulletExists,
    input  logic [8:0]  BulletRow,
    input  logic [9:0]  BulletCol,
    output logic [49:0] Aliens_Grid,
    output logic [8:0]  AliensRow,
    output logic [9:0]  AliensCol,
    output logic        BulletHit,
    output logic [5:0]  HitIndex,
    output logic        FleetCleared,
    output logic        FleetLanded
);
    localparam int CW = $clog2(STEP_FRAMES + 1);
    localparam int PX = ALIEN_W + SPACE_X;
    localparam int PY = ALIEN_H + SPACE_Y;

    typedef enum logic [1:0] {RUN, CLEARED, LANDED} state_t;

    state_t          state;
    logic            dir_left, armed, hit, hit_any, edge_r, edge_l, land;
    logic [CW-1:0]   cnt, reload;
    logic [3:0]      lmin, rmax;
    logic [2:0]      bmax;
    logic [5:0]      hit_idx;
    logic [10:0]     c0, r0, bc, br, x, y;

    assign c0 = {1'b0, AliensCol};
    assign r0 = {2'b0, AliensRow};
    assign bc = {1'b0, BulletCol};
    assign br = {2'b0, BulletRow};

    always_comb begin
        lmin = '0;
        rmax = '0;
        bmax = '0;
        for (int j = 9; j >= 0; j--)
            if (|{Aliens_Grid[40+j], Aliens_Grid[30+j], Aliens_Grid[20+j], Aliens_Grid[10+j], Aliens_Grid[j]}) lmin = 4'(j);
        for (int j = 0; j < 10; j++)
            if (|{Aliens_Grid[40+j], Aliens_Grid[30+j], Aliens_Grid[20+j], Aliens_Grid[10+j], Aliens_Grid[j]}) rmax = 4'(j);
        for (int i = 0; i < 5; i++)
            if (|Aliens_Grid[i*10 +: 10]) bmax = 3'(i);
    end

    // Descending scan so the lowest index wins when cells overlap the point.
    always_comb begin
        hit_any = 1'b0;
        hit_idx = '0;
        x = '0;
        y = '0;
        for (int k = 49; k >= 0; k--) begin
            x = c0 + 11'((k % 10) * PX);
            y = r0 + 11'((k / 10) * PY);
            if (Aliens_Grid[k] && bc >= x && bc <= x + 11'(ALIEN_W - 1) && br >= y && br <= y + 11'(ALIEN_H - 1)) begin
                hit_any = 1'b1;
                hit_idx = 6'(k);
            end
        end
    end

    assign hit    = hit_any && armed && BulletExists && state == RUN;
    assign edge_r = c0 + 11'(rmax) * 11'(PX) + 11'(ALIEN_W + STEP_X) > 11'(SCREEN_W);
    assign edge_l = c0 + 11'(lmin) * 11'(PX) < 11'(STEP_X);
    assign land   = r0 + 11'(bmax) * 11'(PY) + 11'(ALIEN_H) >= 11'(LAND_ROW);

`ifdef ALIEN_SPEEDUP_EN
    int slow;
    assign slow   = STEP_FRAMES - (50 - $countones(Aliens_Grid)) / 4;
    assign reload = CW'(slow > 1 ? slow - 1 : 0);
`else
    assign reload = CW'(STEP_FRAMES - 1);
`endif

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            Aliens_Grid  <= '1;
            AliensRow    <= 9'(START_ROW);
            AliensCol    <= 10'(START_COL);
            dir_left     <= 1'b0;
            cnt          <= CW'(STEP_FRAMES - 1);
            armed        <= 1'b1;
            BulletHit    <= 1'b0;
            HitIndex     <= '0;
            FleetCleared <= 1'b0;
            FleetLanded  <= 1'b0;
            state        <= RUN;
        end else if (Restart) begin
            Aliens_Grid  <= '1;
            AliensRow    <= 9'(START_ROW);
            AliensCol    <= 10'(START_COL);
            dir_left     <= 1'b0;
            cnt          <= CW'(STEP_FRAMES - 1);
            armed        <= 1'b1;
            BulletHit    <= 1'b0;
            HitIndex     <= '0;
            FleetCleared <= 1'b0;
            FleetLanded  <= 1'b0;
            state        <= RUN;
        end else begin
            BulletHit <= hit;
            armed     <= !BulletExists ? 1'b1 : (hit ? 1'b0 : armed);
            if (hit) begin
                Aliens_Grid[hit_idx] <= 1'b0;
                HitIndex             <= hit_idx;
            end
            if (state == RUN) begin
                if (Aliens_Grid == '0) begin
                    state        <= CLEARED;
                    FleetCleared <= 1'b1;
                end else if (land) begin
                    state       <= LANDED;
                    FleetLanded <= 1'b1;
                end
                if (FrameTick) begin
                    cnt <= cnt == '0 ? reload : cnt - CW'(1);
                    if (cnt == '0) begin
                        if (dir_left ? edge_l : edge_r) begin
                            AliensRow <= AliensRow + 9'(STEP_Y);
                            dir_left  <= !dir_left;
                        end else begin
                            AliensCol <= dir_left ? AliensCol - 10'(STEP_X) : AliensCol + 10'(STEP_X);
                        end
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_alien_fleet_ctrl.sv
// tb_alien_fleet_ctrl: random and directed stimulus against a behavioural fleet model.
// Honours ALIEN_SPEEDUP_EN the same way the design does.
module tb_alien_fleet_ctrl;
    logic        Clk = 0, Reset_n = 0, FrameTick = 0, Restart = 0, BulletExists = 0;
    logic [8:0]  BulletRow = 0;
    logic [9:0]  BulletCol = 0;
    logic [49:0] Aliens_Grid;
    logic [8:0]  AliensRow;
    logic [9:0]  AliensCol;
    logic        BulletHit, FleetCleared, FleetLanded;
    logic [5:0]  HitIndex;

    logic        rst2_n = 0;
    logic [49:0] l_grid;
    logic [8:0]  l_row;
    logic [9:0]  l_col;
    logic        l_hit, l_cleared, l_landed;
    logic [5:0]  l_idx;

`ifdef ALIEN_SPEEDUP_EN
    localparam int EXP_INTERVAL = 26;
`else
    localparam int EXP_INTERVAL = 30;
`endif

    alien_fleet_ctrl dut (
        .Clk(Clk), .Reset_n(Reset_n), .FrameTick(FrameTick), .Restart(Restart),
        .BulletExists(BulletExists), .BulletRow(BulletRow), .BulletCol(BulletCol),
        .Aliens_Grid(Aliens_Grid), .AliensRow(AliensRow), .AliensCol(AliensCol),
        .BulletHit(BulletHit), .HitIndex(HitIndex), .FleetCleared(FleetCleared), .FleetLanded(FleetLanded)
    );

    // Fast-marching copy so the fleet reaches the landing row in a short run.
    alien_fleet_ctrl #(.STEP_FRAMES(1)) fast (
        .Clk(Clk), .Reset_n(rst2_n), .FrameTick(1'b1), .Restart(1'b0),
        .BulletExists(1'b0), .BulletRow(9'd0), .BulletCol(10'd0),
        .Aliens_Grid(l_grid), .AliensRow(l_row), .AliensCol(l_col),
        .BulletHit(l_hit), .HitIndex(l_idx), .FleetCleared(l_cleared), .FleetLanded(l_landed)
    );

    always #5 Clk = ~Clk;

    int checks = 0, errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    bit alive[50];
    int mrow, mcol, mcnt, mst, midx;
    bit mleft, marmed, mhit;

    task automatic model_reset();
        foreach (alive[k]) alive[k] = 1'b1;
        mrow = 40; mcol = 20; mleft = 0; mcnt = 29; mst = 0; midx = 0; marmed = 1; mhit = 0;
    endtask

    function automatic int period(input int kills);
`ifdef ALIEN_SPEEDUP_EN
        return (30 - kills / 4 > 1) ? 30 - kills / 4 : 1;
`else
        return 30 + 0 * kills;
`endif
    endfunction

    function automatic logic [63:0] exp_grid();
        logic [63:0] g = '0;
        for (int k = 0; k < 50; k++) g[k] = alive[k];
        return g;
    endfunction

    task automatic compare_all();
        check("grid", {14'd0, Aliens_Grid}, exp_grid());
        check("row", 64'(AliensRow), 64'(mrow));
        check("col", 64'(AliensCol), 64'(mcol));
        check("hit", 64'(BulletHit), 64'(mhit));
        check("hit_index", 64'(HitIndex), 64'(midx));
        check("cleared", 64'(FleetCleared), 64'(mst == 1));
        check("landed", 64'(FleetLanded), 64'(mst == 2));
    endtask

    // One clock: predict from the model and current inputs, then compare after the edge.
    task automatic tick();
        bit n_alive[50];
        int n_row, n_col, n_cnt, n_st, n_idx, live, lmin, rmax, bmax, hk, bx, by, cx, cy;
        bit n_left, n_armed, n_hit, rs;
        rs = Restart;
        n_alive = alive; n_row = mrow; n_col = mcol; n_cnt = mcnt; n_st = mst; n_idx = midx;
        n_left = mleft; n_armed = marmed; n_hit = 0;
        live = 0; lmin = 10; rmax = 0; bmax = 0; hk = -1;
        bx = int'(BulletCol); by = int'(BulletRow);
        for (int k = 0; k < 50; k++) if (alive[k]) begin
            live++;
            if (k % 10 < lmin) lmin = k % 10;
            if (k % 10 > rmax) rmax = k % 10;
            bmax = k / 10;
            cx = mcol + (k % 10) * 40;
            cy = mrow + (k / 10) * 30;
            if (hk < 0 && bx >= cx && bx <= cx + 29 && by >= cy && by <= cy + 19) hk = k;
        end
        if (live == 0) lmin = 0;
        if (mst == 0 && BulletExists && marmed && hk >= 0) begin
            n_hit = 1; n_idx = hk; n_alive[hk] = 0;
        end
        n_armed = !BulletExists ? 1 : (n_hit ? 0 : marmed);
        if (mst == 0) begin
            if (live == 0) n_st = 1;
            else if (mrow + bmax * 30 + 20 >= 440) n_st = 2;
            if (FrameTick) begin
                if (mcnt == 0) begin
                    n_cnt = period(50 - live) - 1;
                    if (!mleft && mcol + rmax * 40 + 34 > 640) begin n_row = mrow + 10; n_left = 1; end
                    else if (mleft && mcol + lmin * 40 < 4) begin n_row = mrow + 10; n_left = 0; end
                    else n_col = mleft ? mcol - 4 : mcol + 4;
                end else n_cnt = mcnt - 1;
            end
        end
        @(posedge Clk);
        #1;
        if (rs) model_reset();
        else begin
            alive = n_alive; mrow = n_row; mcol = n_col; mcnt = n_cnt; mst = n_st;
            midx = n_idx; mleft = n_left; marmed = n_armed; mhit = n_hit;
        end
        compare_all();
    endtask

    task automatic restart();
        Restart = 1; FrameTick = 0; BulletExists = 0;
        tick();
        Restart = 0;
    endtask

    task automatic shoot(input int k);
        BulletCol = 10'(mcol + (k % 10) * 40 + 5);
        BulletRow = 9'(mrow + (k / 10) * 30 + 5);
        BulletExists = 1;
        tick();
        BulletExists = 0;
        tick();
    endtask

    task automatic steps(input int n);
        FrameTick = 1;
        repeat (n * 30) tick();
        FrameTick = 0;
    endtask

    initial begin
        int k, n;
        logic [9:0] prev;
        repeat (2) @(posedge Clk);
        #1;
        check("rst_grid", {14'd0, Aliens_Grid}, 64'h3_FFFF_FFFF_FFFF);
        check("rst_row", 64'(AliensRow), 64'd40);
        check("rst_col", 64'(AliensCol), 64'd20);
        check("rst_flags", {61'd0, BulletHit, FleetCleared, FleetLanded}, 64'd0);
        model_reset();
        Reset_n = 1;

        for (int c = 0; c < 4000; c++) begin
            FrameTick = ($urandom % 4) != 0;
            Restart = ($urandom % 600) == 0;
            BulletExists = ($urandom % 3) != 0;
            if ($urandom % 8 == 0) begin
                k = $urandom % 50;
                BulletCol = 10'(mcol + (k % 10) * 40 + $urandom % 30);
                BulletRow = 9'(mrow + (k / 10) * 30 + $urandom % 20);
            end else begin
                BulletCol = 10'($urandom);
                BulletRow = 9'($urandom);
            end
            tick();
            if (c == 2000) begin
                Reset_n = 0;
                #1;
                check("async_grid", {14'd0, Aliens_Grid}, 64'h3_FFFF_FFFF_FFFF);
                check("async_pos", {AliensRow, AliensCol}, {9'd40, 10'd20});
                check("async_flags", {61'd0, BulletHit, FleetCleared, FleetLanded}, 64'd0);
                model_reset();
                Reset_n = 1;
            end
        end

        restart();
        FrameTick = 1;
        repeat (29) tick();
        FrameTick = 0;
        tick();
        check("t2_col29", 64'(AliensCol), 64'd20);
        FrameTick = 1;
        tick();
        FrameTick = 0;
        check("t2_col30", 64'(AliensCol), 64'd24);

        restart();
        steps(57);
        check("t3_col57", 64'(AliensCol), 64'd248);
        steps(1);
        check("t3_pos58", {AliensRow, AliensCol}, {9'd50, 10'd248});
        steps(1);
        check("t3_col59", 64'(AliensCol), 64'd244);

        restart();
        BulletCol = 25; BulletRow = 45; BulletExists = 1;
        tick();
        check("t4_pulse", 64'(BulletHit), 64'd1);
        check("t4_index", 64'(HitIndex), 64'd0);
        check("t4_grid0", 64'(Aliens_Grid[0]), 64'd0);
        tick();
        check("t4_held", 64'(BulletHit), 64'd0);
        BulletExists = 0;
        tick();
        BulletCol = 55; BulletExists = 1;
        tick();
        check("t4_gap", 64'(BulletHit), 64'd0);
        check("t4_gap_grid", {14'd0, Aliens_Grid}, 64'h3_FFFF_FFFF_FFFE);

        restart();
        for (int i = 0; i < 50; i++) shoot(i);
        tick();
        check("t5_cleared", 64'(FleetCleared), 64'd1);
        FrameTick = 1;
        repeat (40) tick();
        FrameTick = 0;
        check("t5_frozen", {AliensRow, AliensCol}, {9'd40, 10'd20});
        restart();
        check("t5_restart_grid", {14'd0, Aliens_Grid}, 64'h3_FFFF_FFFF_FFFF);
        check("t5_restart_flags", {62'd0, FleetCleared, FleetLanded}, 64'd0);

        restart();
        for (int i = 0; i < 16; i++) shoot(i);
        FrameTick = 1;
        prev = AliensCol;
        n = 0;
        while (AliensCol == prev && n < 100) begin tick(); n++; end
        check("t6_first_step", 64'(n), 64'd30);
        prev = AliensCol;
        n = 0;
        while (AliensCol == prev && n < 100) begin tick(); n++; end
        check("t6_interval", 64'(n), 64'(EXP_INTERVAL));
        FrameTick = 0;

        rst2_n = 1;
        n = 0;
        while (!l_landed && n < 5000) begin @(posedge Clk); #1; n++; end
        check("land_flag", 64'(l_landed), 64'd1);
        check("land_row", 64'(l_row), 64'd300);
        repeat (20) @(posedge Clk);
        #1;
        check("land_hold", {63'd0, l_landed}, 64'd1);
        check("land_row_hold", 64'(l_row), 64'd300);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end
endmodule
